re_buffer_reader: RTL and testbench
===================================

RE_BUFFER_READER -- requirements
Module: re_buffer_reader

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, 16, RAM address width.
- DATA_WIDTH, 32, RE sample width.
- INITIAL_ADDR, 0, first read address.
- FINAL_ADDR, 575, last read address; FINAL_ADDR >= INITIAL_ADDR.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  one-cycle pulse; the write side has filled the buffer.
REQ-005 rd_en  output  1  RAM read strobe.
REQ-006 rd_addr  output  ADDR_WIDTH  RAM read address.
REQ-007 rd_data  input  DATA_WIDTH  RAM data; valid exactly 1 cycle after rd_en.
REQ-008 out_data  output  DATA_WIDTH  stream data.
REQ-009 out_valid  output  1  stream valid.
REQ-010 out_ready  input  1  downstream accept.
REQ-011 busy  output  1  high in READ or DRAIN.
REQ-012 done  output  1  one-cycle pulse after the last beat is accepted.
REQ-013 overrun  output  1  one-cycle pulse when start arrives while busy.

Function
REQ-014 FSM states SHALL be IDLE, READ and DRAIN.
- IDLE->READ on start.
- READ->DRAIN in the cycle rd_en issues FINAL_ADDR.
- DRAIN->IDLE when the FIFO is empty and no read is in flight; done asserts in the first IDLE cycle.
REQ-015 The block SHALL read N = FINAL_ADDR-INITIAL_ADDR+1 addresses per frame, in order INITIAL_ADDR..FINAL_ADDR, each exactly once.
REQ-016 rd_addr SHALL be a registered counter: INITIAL_ADDR in IDLE, +1 per rd_en, reloaded to INITIAL_ADDR after FINAL_ADDR issues; width wrap never occurs.
REQ-017 rd_data SHALL be captured into a 2-entry FIFO in the cycle after each rd_en.
REQ-018 rd_en SHALL assert only in READ, and only when fifo_count + inflight - (out_valid & out_ready) < 2 (inflight = rd_en of the previous cycle); the FIFO never overflows.
REQ-019 out_valid SHALL equal FIFO non-empty, and out_data SHALL be the FIFO head.
REQ-020 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
REQ-021 A FIFO push and pop in the same cycle SHALL leave the count unchanged and preserve order.
REQ-022 Latency: start at cycle T SHALL give rd_en with rd_addr=INITIAL_ADDR at T+1 and first out_valid at T+3.
REQ-023 With out_ready held high, throughput SHALL be 1 beat/cycle: the last beat is accepted at T+N+2, done pulses at T+N+3, and busy is high from T+1 to T+N+2.
REQ-024 A start while busy SHALL be ignored (no state change) and SHALL pulse overrun for 1 cycle.
REQ-025 A start in the same cycle as done (IDLE) SHALL be accepted normally.
REQ-026 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-027 On rst=0, immediately and regardless of state: state=IDLE, rd_addr=INITIAL_ADDR, FIFO empty, in-flight flag cleared, and rd_en, out_valid, busy, done, overrun all 0.
REQ-028 out_data SHALL reset to 0.
REQ-029 A reset mid-frame SHALL discard in-flight data; after release the block waits for a new start.

Verification
REQ-030 Default parameters, RAM[a]=a, out_ready=1, start at T -> rd_addr 0..575 on T+1..T+576; out_data 0..575 on T+3..T+578; done at T+579 only; busy T+1..T+578.
REQ-031 out_ready toggling 1,0,0,1 repeating -> all 576 values delivered in order with no loss or duplication; data stable while stalled; rd_en never issued with FIFO+inflight at 2.
REQ-032 out_ready=0 for 20 cycles after start -> exactly 2 rd_en issued (addr 0,1); out_valid=1 with out_data=0 held; raising ready resumes at addr 2.
REQ-033 start pulsed at T+100 during a frame -> overrun=1 at T+101 for 1 cycle; frame completes unchanged.
REQ-034 rst asserted at T+50 -> all outputs 0 and rd_addr=0 asynchronously; a new start after release replays from addr 0.
REQ-035 INITIAL_ADDR=4, FINAL_ADDR=4 -> single rd_en at addr 4; one beat; start re-asserted in the done cycle is accepted.

Source files
------------

// File: rtl/re_buffer_reader.sv
// Streams one frame of RE samples out of a RAM buffer into a valid/ready port.
// A 2-entry FIFO absorbs the one-cycle RAM latency so reads can run at full rate.
module re_buffer_reader #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int INITIAL_ADDR = 0,
    parameter int FINAL_ADDR   = 575
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(INITIAL_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(FINAL_ADDR);

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            count_q, count_d;
    logic                  done_q, overrun_q;
    logic                  push, pop, last_issue;

    assign push = inflight_q;
    assign pop  = (count_q != 2'd0) && out_ready;

    // Occupancy counts the read still in flight and credits a pop happening this cycle.
    assign rd_en = (state_q == ST_READ) &&
                   (({1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop}) < 3'd2);

    assign last_issue = rd_en && (addr_q == ADDR_LAST);
    assign count_d    = count_q + {1'b0, push} - {1'b0, pop};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_READ;
            ST_READ:  if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if ((count_d == 2'd0) && !push) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        if (last_issue || (state_q == ST_IDLE)) begin
            addr_d = ADDR_FIRST;
        end else if (rd_en) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= ADDR_FIRST;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            inflight_q <= rd_en;
            count_q    <= count_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            done_q     <= (state_q == ST_DRAIN) && (state_d == ST_IDLE);
            overrun_q  <= start && (state_q != ST_IDLE);
        end
    end

    // Storage entries are plain flops so the head can reset to zero.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                fifo_q[gi] <= '0;
            end else if (push && (wr_ptr_q == 1'(gi))) begin
                fifo_q[gi] <= rd_data;
            end
        end
    end

    assign rd_addr   = addr_q;
    assign out_data  = fifo_q[rd_ptr_q];
    assign out_valid = (count_q != 2'd0);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_re_buffer_reader.sv
// Randomized frame-level bench for re_buffer_reader: a scoreboard of expected
// addresses/beats plus a single-address instance for the N=1 corner.
module tb_re_buffer_reader;

    localparam int AW   = 16;
    localparam int DW   = 32;
    localparam int INIT = 0;
    localparam int FIN  = 575;
    localparam int N    = FIN - INIT + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, out_ready;
    logic          rd_en, out_valid, busy, done, overrun;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] out_data;

    logic          s_start, s_out_ready;
    logic          s_rd_en, s_out_valid, s_busy, s_done, s_overrun;
    logic [AW-1:0] s_rd_addr;
    logic [DW-1:0] s_rd_data = '0;
    logic [DW-1:0] s_out_data;

    re_buffer_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INITIAL_ADDR(INIT), .FINAL_ADDR(FIN)) u_dut (
        .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .overrun(overrun));

    re_buffer_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INITIAL_ADDR(4), .FINAL_ADDR(4)) u_dut_s (
        .clk(clk), .rst(rst), .start(s_start), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
        .rd_data(s_rd_data), .out_data(s_out_data), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .busy(s_busy), .done(s_done), .overrun(s_overrun));

    function automatic logic [DW-1:0] ram_word(input int a);
        return {16'hC3A5 ^ 16'(a), 16'(a)};
    endfunction

    // RAM models: data appears one cycle after the read strobe.
    always @(posedge clk) if (rd_en)   rd_data   <= ram_word(int'(rd_addr));
    always @(posedge clk) if (s_rd_en) s_rd_data <= ram_word(int'(s_rd_addr));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    int T = 0;
    int mode = 0;
    int start_cyc = -1, ovr_cyc = -1, s_start_cyc = -1, s_start2 = -1;
    bit mon_on = 0;

    int exp_addr, issued, accepted, first_rd, first_val, last_acc, busy_cnt, done_cnt, done_cyc;
    bit stall_prev;
    logic [DW-1:0] prev_data;

    task sample;
        bit pop_now;
        int outst;
        pop_now = out_valid && out_ready;
        outst   = issued - accepted;
        if (rd_en) begin
            chk("rd_addr", 64'(rd_addr), 64'(exp_addr));
            chk("no_overflow", 64'((outst - int'(pop_now)) < 2), 64'(1));
            issued++;
            exp_addr++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (stall_prev) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_data", 64'(out_data), 64'(prev_data));
        end
        if (pop_now) begin
            chk("out_data", 64'(out_data), 64'(ram_word(INIT + accepted)));
            accepted++;
            last_acc = cyc;
        end
        if (out_valid && first_val < 0) first_val = cyc;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (ovr_cyc >= 0 && cyc == ovr_cyc + 1) chk("overrun", 64'(overrun), 64'(1));
        else if (overrun) chk("overrun_spurious", 64'(overrun), 64'(0));
        if (mode == 3 && cyc == T + 20) begin
            chk("stall_reads", 64'(issued), 64'(2));
            chk("stall_valid", 64'(out_valid), 64'(1));
            chk("stall_data", 64'(out_data), 64'(ram_word(INIT)));
        end
        stall_prev = out_valid && !out_ready;
        prev_data  = out_data;
    endtask

    task tick;
        @(posedge clk);
        cyc++;
        #1;
        start       = (cyc == start_cyc) || (cyc == ovr_cyc);
        s_start     = (cyc == s_start_cyc) || (cyc == s_start2);
        s_out_ready = 1'b1;
        case (mode)
            1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       out_ready = 1'($urandom_range(0, 1));
            3:       out_ready = (cyc > T + 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            default: out_ready = 1'b1;
        endcase
        @(negedge clk);
        if (mon_on) sample();
    endtask

    task model_clear;
        exp_addr = INIT; issued = 0; accepted = 0; first_rd = -1; first_val = -1;
        last_acc = -1; busy_cnt = 0; done_cnt = 0; done_cyc = -1; stall_prev = 0;
    endtask

    task run_frame(input int m, input int ovr_off);
        mode      = m;
        T         = cyc + 1;
        start_cyc = T;
        ovr_cyc   = (ovr_off > 0) ? T + ovr_off : -1;
        model_clear();
        for (int g = 0; g < 6000 && done_cnt == 0; g++) tick();
        chk("done_seen", 64'(done_cnt), 64'(1));
        repeat (3) tick();
        chk("done_once", 64'(done_cnt), 64'(1));
        chk("beats", 64'(accepted), 64'(N));
        chk("reads", 64'(issued), 64'(N));
        chk("done_after_last", 64'(done_cyc), 64'(last_acc + 1));
        if (m == 0) begin
            chk("first_rd_lat", 64'(first_rd), 64'(T + 1));
            chk("first_valid_lat", 64'(first_val), 64'(T + 3));
            chk("last_accept", 64'(last_acc), 64'(T + N + 2));
            chk("done_lat", 64'(done_cyc), 64'(T + N + 3));
            chk("busy_cycles", 64'(busy_cnt), 64'(N + 2));
        end
        $display("frame mode=%0d ovr=%0d T=%0d beats=%0d done_at=%0d", m, ovr_off, T, accepted, done_cyc);
    endtask

    task chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, 64'(rd_en), 64'(0));
        chk({tag, "_rd_addr"}, 64'(rd_addr), 64'(INIT));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_out_data"}, 64'(out_data), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done"}, 64'(done), 64'(0));
        chk({tag, "_overrun"}, 64'(overrun), 64'(0));
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; s_start = 1'b0; out_ready = 1'b0; s_out_ready = 1'b1;
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst = 1'b1;
        tick();
        mon_on = 1;

        run_frame(0, 0);
        run_frame(1, 0);
        run_frame(2, 0);
        run_frame(3, 0);
        run_frame(0, 100);

        // Mid-frame asynchronous reset, then a fresh frame from the first address.
        mode = 0; T = cyc + 1; start_cyc = T; ovr_cyc = -1;
        model_clear();
        while (cyc < T + 50) tick();
        mon_on = 0;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        $display("mid-frame reset at cyc=%0d", cyc);
        repeat (2) tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("wait_start_busy", 64'(busy), 64'(0));
        chk("wait_start_rd_en", 64'(rd_en), 64'(0));
        stall_prev = 0;
        mon_on = 1;
        run_frame(2, 0);

        // Single-address instance: one read, one beat, restart in the done cycle.
        mon_on = 0;
        T = cyc + 1; s_start_cyc = T; s_start2 = T + 4;
        for (int k = 0; k < 10; k++) begin
            tick();
            case (cyc - T)
                1: begin
                    chk("s_rd_en1", 64'(s_rd_en), 64'(1));
                    chk("s_rd_addr1", 64'(s_rd_addr), 64'(4));
                    chk("s_busy1", 64'(s_busy), 64'(1));
                end
                2: chk("s_rd_en2", 64'(s_rd_en), 64'(0));
                3: begin
                    chk("s_valid3", 64'(s_out_valid), 64'(1));
                    chk("s_data3", 64'(s_out_data), 64'(ram_word(4)));
                    chk("s_done3", 64'(s_done), 64'(0));
                end
                4: begin
                    chk("s_done4", 64'(s_done), 64'(1));
                    chk("s_busy4", 64'(s_busy), 64'(0));
                end
                5: begin
                    chk("s_restart_rd_en", 64'(s_rd_en), 64'(1));
                    chk("s_restart_addr", 64'(s_rd_addr), 64'(4));
                    chk("s_no_overrun", 64'(s_overrun), 64'(0));
                end
                8: chk("s_done_again", 64'(s_done), 64'(1));
                default: ;
            endcase
        end
        $display("single-address frames T=%0d restart=%0d", T, s_start2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
